entropy_extractor: RTL
======================

# entropy_extractor

Parametrised successor to the single-byte randomness extractor. It harvests low-order bits from AC97 audio samples into a KEY_W-bit key register for the phone's key-exchange logic. Additions over the previous block:
- explicit request/valid handshake;
- edge-qualified sample capture, so a held `ready` is one sample;
- configurable bits per sample;
- optional von Neumann debiasing.

It sits between the AC97 capture path and the crypto/key-agreement FSM.

## Interface
Parameters:
- SAMPLE_W, 8: width of `from_ac97_data`.
- KEY_W, 256: key length in bits. Must be a multiple of BITS_PER_SAMPLE.
- BITS_PER_SAMPLE, 1: low-order bits taken per sample in raw mode. Range 1..SAMPLE_W.
- VON_NEUMANN, 0: 1 enables debiasing mode (bit 0 only, BITS_PER_SAMPLE ignored).

Ports:
- clock, input, 1: single system clock, all logic rising-edge.
- reset, input, 1: synchronous, active-high.
- from_ac97_data, input, SAMPLE_W: audio sample, stable while `ready` is high.
- ready, input, 1: sample-available strobe, may be held high for several cycles.
- request, input, 1: one-cycle pulse that starts or restarts collection of a fresh key.
- key, output, KEY_W: collected key. Newest bits sit at the LSB end.
- key_valid, output, 1: high while `key` holds a complete KEY_W-bit key.
- bit_count, output, $clog2(KEY_W+1): bits collected so far.

## Operation
- States:
  - IDLE: entered on reset.
  - COLLECT
  - DONE
- Reset values: state=IDLE, key=0, key_valid=0, bit_count=0, ready_d=0, vn_pending=0, vn_have=0.
- Accept event: `ready`=1 and `ready_d`=0 on a clock edge.
  - `ready_d` is a register that tracks `ready` every cycle in all states.
  - A `ready` held high for N cycles gives exactly one accept.
- Transitions:
  - IDLE to COLLECT on `request`. Clears key, bit_count, vn_have.
  - COLLECT to DONE when bit_count reaches KEY_W. key_valid=1 on the same edge.
  - DONE to COLLECT on `request`. Clears everything and drops key_valid.
  - COLLECT plus `request` restarts: clear and stay in COLLECT.
- In IDLE and DONE, accepts are ignored. key and key_valid are frozen.
- Raw mode (VON_NEUMANN=0): on each accept in COLLECT:
  - key <= {key[KEY_W-1-BITS_PER_SAMPLE:0], from_ac97_data[BITS_PER_SAMPLE-1:0]}.
  - bit_count += BITS_PER_SAMPLE.
- Von Neumann mode (VON_NEUMANN=1): bit b = from_ac97_data[0] on each accept.
  - vn_have=0: store vn_pending=b, set vn_have=1.
  - vn_have=1: clear vn_have.
    - If vn_pending != b: shift in vn_pending (pair 10 gives 1, pair 01 gives 0) and bit_count += 1.
    - Pairs 00 and 11 are discarded.
- Arithmetic: bit_count never exceeds KEY_W. It saturates because collection stops at DONE.
- Simultaneous `request` and accept: `request` wins and the sample is dropped. The next accept needs a new `ready` rise.
- `reset` mid-collection: everything returns to reset values and any partial key is discarded. `ready` high during the first post-reset cycle is an accept edge, but it is ignored because the state is IDLE.

## Timing
- One-cycle latency: an accept at edge n updates key and bit_count, visible after edge n.
- key_valid rises on the edge that shifts in the final bit. key holds the complete value on that same cycle.
- `request` at edge n: key=0, key_valid=0, bit_count=0 visible after edge n. Accepts count from edge n+1.
- Minimum accept spacing is 2 cycles (`ready` low for at least 1 cycle between samples).
- No combinational path from inputs to outputs.

## Test plan
- Raw mode, KEY_W=8, BITS_PER_SAMPLE=2:
  - Stimulus: `request`, then samples 45, 103, 2, 0, each with `ready` held 3 cycles and 3 cycles low between.
  - Required: bit_count steps 2, 4, 6, 8; key=0x78; key_valid=1 one cycle after the 4th accept edge; exactly 4 shifts.
- Ignore in DONE:
  - Stimulus: after the previous case, present further samples 255, 255.
  - Required: key stays 0x78, key_valid stays 1. Then `request` gives key=0, key_valid=0, bit_count=0.
- Von Neumann mode, KEY_W=4:
  - Stimulus: bit-0 stream 1,0, 1,1, 0,1, 0,0, 1,0, 0,1 over 12 accepts.
  - Required: bits emitted 1,0,1,0; key=0xA; key_valid high after the 12th accept; bit_count=2 after the 6th accept.
- Collision:
  - Stimulus: `request` and a `ready` rise on the same edge, with `ready` then held.
  - Required: no sample counted (bit_count=0). Counting resumes only on the next `ready` rise.
- Reset mid-operation:
  - Stimulus: raw mode, KEY_W=8, BITS_PER_SAMPLE=1; assert `reset` for 1 cycle after 3 accepts.
  - Required: key=0, bit_count=0, key_valid=0, state IDLE. Accepts are ignored until `request`.
- Restart in COLLECT:
  - Stimulus: `request` after 5 of 8 bits.
  - Required: bit_count=0; a full key needs 8 new accepts.

Source files
------------

// File: rtl/entropy_extractor.sv
// entropy_extractor
// Harvests low-order bits from AC97 audio samples into a KEY_W-bit key for
// the key-agreement logic. A rising edge of `ready` is one sample; `request`
// starts (or restarts) collection of a fresh key.
//
// Ports:
//   clock          - system clock, all logic on the rising edge
//   reset          - synchronous, active-high
//   from_ac97_data - audio sample, stable while `ready` is high
//   ready          - sample-available strobe, may be held for several cycles
//   request        - one-cycle pulse: clear and begin collecting a new key
//   key            - collected key, newest bits at the LSB end
//   key_valid      - high while `key` holds a complete KEY_W-bit key
//   bit_count      - number of key bits collected so far
//
// Parameters:
//   SAMPLE_W        - width of from_ac97_data
//   KEY_W           - key length, a multiple of BITS_PER_SAMPLE
//   BITS_PER_SAMPLE - low-order bits taken per sample in raw mode
//   VON_NEUMANN     - 1: debias bit 0 of each sample pair (10 -> 1, 01 -> 0)
module entropy_extractor #(
  parameter int SAMPLE_W        = 8,
  parameter int KEY_W           = 256,
  parameter int BITS_PER_SAMPLE = 1,
  parameter int VON_NEUMANN     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SAMPLE_W-1:0]          from_ac97_data,
  input  logic                         ready,
  input  logic                         request,
  output logic [KEY_W-1:0]             key,
  output logic                         key_valid,
  output logic [$clog2(KEY_W+1)-1:0]   bit_count
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  state_t             state_q;
  logic [KEY_W-1:0]   key_q;
  logic               key_valid_q;
  logic [CNT_W-1:0]   bit_count_q;
  logic               ready_prev_q;
  logic               vn_pending_q;
  logic               vn_have_q;

  // Next values of the datapath for the case where a sample is accepted.
  logic               accept;
  logic               shift_en_d;
  logic [KEY_W-1:0]   key_d;
  logic [CNT_W-1:0]   bit_count_d;

  // One accept per rising edge of ready, however long it is held.
  assign accept = ready & ~ready_prev_q;

  generate
    if (VON_NEUMANN != 0) begin : g_vn
      // Only the second sample of an unequal pair produces a bit; the
      // emitted bit is the first sample of the pair.
      always_comb begin
        shift_en_d  = vn_have_q & (vn_pending_q != from_ac97_data[0]);
        key_d       = (key_q << 1) | KEY_W'(vn_pending_q);
        bit_count_d = bit_count_q + CNT_W'(1);
      end
    end else begin : g_raw
      always_comb begin
        shift_en_d  = 1'b1;
        key_d       = (key_q << BITS_PER_SAMPLE)
                    | KEY_W'(from_ac97_data[BITS_PER_SAMPLE-1:0]);
        bit_count_d = bit_count_q + CNT_W'(BITS_PER_SAMPLE);
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      bit_count_q  <= '0;
      ready_prev_q <= 1'b0;
      vn_pending_q <= 1'b0;
      vn_have_q    <= 1'b0;
    end else begin
      ready_prev_q <= ready;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Accepts are ignored here; key and key_valid stay frozen.
          if (request) begin
            state_q      <= ST_COLLECT;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            bit_count_q  <= '0;
            vn_pending_q <= 1'b0;
            vn_have_q    <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (request) begin
            // Restart; a sample arriving on this same edge is dropped.
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            bit_count_q  <= '0;
            vn_pending_q <= 1'b0;
            vn_have_q    <= 1'b0;
          end else if (accept) begin
            if (VON_NEUMANN != 0) begin
              vn_have_q <= ~vn_have_q;
              if (!vn_have_q) begin
                vn_pending_q <= from_ac97_data[0];
              end
            end
            if (shift_en_d) begin
              key_q       <= key_d;
              bit_count_q <= bit_count_d;
              if (bit_count_d == CNT_W'(KEY_W)) begin
                state_q     <= ST_DONE;
                key_valid_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign bit_count = bit_count_q;

  // Sample bits and debias state that a given configuration does not read.
  logic unused_sink;
  assign unused_sink = ^{from_ac97_data, vn_pending_q, vn_have_q};

endmodule
